ysyx_23060332_lsu: RTL and testbench

Load/store unit sitting directly upstream of the NPC data memory block. It accepts one memory-op request from EXU over a valid/ready handshake and drives the memory port (ren/raddr, wen/waddr/wdata/wmask). For loads it applies the RV32 extraction and sign extension to the byte-aligned word the memory returns, then presents the result to WBU over a second valid/ready handshake. A parameterised access latency models slower memories. One request is in flight at a time.

---
 rtl/ysyx_23060332_lsu_pkg.sv | 24 ++
 rtl/ysyx_23060332_lsu_ext.sv | 35 +++
 rtl/ysyx_23060332_lsu.sv | 141 ++++++++++++++
 tb/tb_ysyx_23060332_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the LSU: RV32 load/store funct3 encodings, bus widths
// and the LSU state encoding.
package ysyx_23060332_lsu_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_DATA_BUS = 32;
  localparam logic [MEM_DATA_BUS-1:0] ZERO_WORD = '0;

  localparam logic [2:0] LB_F3  = 3'b000;
  localparam logic [2:0] LH_F3  = 3'b001;
  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] LBU_F3 = 3'b100;
  localparam logic [2:0] LHU_F3 = 3'b101;
  localparam logic [2:0] SB_F3  = 3'b000;
  localparam logic [2:0] SH_F3  = 3'b001;
  localparam logic [2:0] SW_F3  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060332_lsu_ext.sv
// Combinational load-data extension and store byte-mask generation from funct3.
module ysyx_23060332_lsu_ext
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int DW = MEM_DATA_BUS
) (
  input  logic [2:0]    func3,
  input  logic [DW-1:0] raw_rdata,
  output logic [DW-1:0] ext_rdata,
  output logic [7:0]    wmask
);

  // Unlisted load encodings fall back to a full-word read.
  always_comb begin
    ext_rdata = raw_rdata;
    case (func3)
      LB_F3:   ext_rdata = {{(DW-8){raw_rdata[7]}}, raw_rdata[7:0]};
      LH_F3:   ext_rdata = {{(DW-16){raw_rdata[15]}}, raw_rdata[15:0]};
      LBU_F3:  ext_rdata = {{(DW-8){1'b0}}, raw_rdata[7:0]};
      LHU_F3:  ext_rdata = {{(DW-16){1'b0}}, raw_rdata[15:0]};
      default: ext_rdata = raw_rdata;
    endcase
  end

  always_comb begin
    wmask = 8'h0F;
    case (func3)
      SB_F3:   wmask = 8'h01;
      SH_F3:   wmask = 8'h03;
      SW_F3:   wmask = 8'h0F;
      default: wmask = 8'h0F;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one request in flight, IDLE -> ACCESS -> RESP, with a
// MEM_LAT-cycle memory access window and a valid/ready result port.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = MEM_ADDR_BUS,
  parameter int DW      = MEM_DATA_BUS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_ren,
  input  logic          in_wen,
  input  logic [2:0]    in_func3,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [4:0]    in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_rdata,
  output logic [4:0]    out_rd,
  output logic          out_is_load,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask
);

  // Both handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable while valid is high and ready is low.

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  lsu_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    func3_q, func3_d;
  logic [4:0]    rd_q, rd_d;
  logic          is_load_q, is_load_d;
  logic          is_store_q, is_store_d;
  logic [DW-1:0] ext_rdata;
  logic [7:0]    wmask;

  ysyx_23060332_lsu_ext #(.DW(DW)) u_ext (
    .func3     (func3_q),
    .raw_rdata (mem_rdata),
    .ext_rdata (ext_rdata),
    .wmask     (wmask)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    func3_d    = func3_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          func3_d    = in_func3;
          rd_d       = in_rd;
          is_load_d  = in_ren;
          // A request flagged as both load and store is executed as a load only.
          is_store_d = in_wen & ~in_ren;
          rdata_d    = ZERO_WORD;
          if (in_ren | in_wen) begin
            state_d = LSU_ACCESS;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = LSU_RESP;
          end
        end
      end
      LSU_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = LSU_RESP;
          if (is_load_q) rdata_d = ext_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LSU_RESP: begin
        if (out_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      func3_q    <= 3'd0;
      rd_q       <= 5'd0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      func3_q    <= func3_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
    end
  end

  assign in_ready    = (state_q == LSU_IDLE);
  assign out_valid   = (state_q == LSU_RESP);
  assign out_rdata   = rdata_q;
  assign out_rd      = rd_q;
  assign out_is_load = is_load_q;

  // The counter still holds its load value only in the first ACCESS cycle,
  // which gives exactly one write strobe per store.
  assign mem_ren   = (state_q == LSU_ACCESS) && is_load_q;
  assign mem_wen   = (state_q == LSU_ACCESS) && is_store_q && (cnt_q == CNT_INIT);
  assign mem_wmask = mem_wen ? wmask : 8'h00;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Self-checking bench for ysyx_23060332_lsu: table of load/store/non-mem ops,
// random loads, plus hand-written backpressure and mid-access reset sequences.
module tb_ysyx_23060332_lsu;

  localparam int LAT = 3;
  localparam int EW  = 38;  // {rdata, rd, is_load}

  typedef struct {
    bit          ren;
    bit          wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_mask;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_ren = 1'b0, in_wen = 1'b0;
  logic [2:0]  in_func3 = 3'd0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_is_load;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_rdata = '0, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[16];

  ysyx_23060332_lsu #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_is_load(out_is_load),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(bit ren, bit wen, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [4:0] rd, logic [31:0] rdata,
                              logic [31:0] exp_rdata, logic [7:0] exp_mask, int hold);
    vec_t v;
    v.ren = ren; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.exp_rdata = exp_rdata; v.exp_mask = exp_mask; v.hold = hold;
    return v;
  endfunction

  // Reference RV32 load extraction used for the random loads.
  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic drive_req(input vec_t v);
    in_valid = 1'b1; in_ren = v.ren; in_wen = v.wen; in_func3 = v.f3;
    in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd; mem_rdata = v.rdata;
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int nren, nwen, lat;
    bit raddr_ok, stable_ok;
    logic [31:0] got_waddr, got_wdata;
    logic [7:0]  got_mask;
    logic [EW-1:0] e;
    got_waddr = '0; got_wdata = '0; got_mask = '0;
    @(negedge clk);
    check({nm, "_in_ready"}, in_ready, 1'b1);
    drive_req(v);
    out_ready = (v.hold == 0);
    exp_q.push_back({v.exp_rdata, v.rd, v.ren});
    @(negedge clk);
    in_valid = 1'b0;
    nren = 0; nwen = 0; lat = 0; raddr_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (mem_ren) begin
        nren++;
        if (mem_raddr !== v.addr) raddr_ok = 1'b0;
      end
      if (mem_wen) begin
        nwen++;
        got_waddr = mem_waddr; got_wdata = mem_wdata; got_mask = mem_wmask;
      end
      lat++;
      @(negedge clk);
    end
    check({nm, "_latency"}, lat, (v.ren | v.wen) ? LAT : 0);
    check({nm, "_ren_cycles"}, nren, v.ren ? LAT : 0);
    check({nm, "_wen_cycles"}, nwen, (v.wen && !v.ren) ? 1 : 0);
    if (v.ren) check({nm, "_raddr"}, raddr_ok, 1'b1);
    if (v.wen && !v.ren)
      check({nm, "_write"}, {got_waddr, got_wdata, got_mask}, {v.addr, v.wdata, v.exp_mask});
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({nm, "_result"}, {out_rdata, out_rd, out_is_load}, e);
      stable_ok = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        if (!out_valid || in_ready || mem_ren || ({out_rdata, out_rd, out_is_load} !== e))
          stable_ok = 1'b0;
      end
      if (v.hold > 0) check({nm, "_hold_stable"}, stable_ok, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      check({nm, "_released"}, {in_ready, out_valid}, 2'b10);
    end else begin
      check({nm, "_out_valid_seen"}, out_valid, 1'b1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t v;
    logic [2:0] f3s[5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    vecs[0]  = mk(1, 0, 3'b010, 32'h8000_0000, 32'h0, 5'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00, 0);
    vecs[1]  = mk(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd2, 32'h0000_0080, 32'hFFFF_FF80, 8'h00, 0);
    vecs[2]  = mk(1, 0, 3'b100, 32'h8000_0003, 32'h0, 5'd3, 32'h0000_0080, 32'h0000_0080, 8'h00, 0);
    vecs[3]  = mk(1, 0, 3'b001, 32'h8000_0010, 32'h0, 5'd4, 32'h0000_8001, 32'hFFFF_8001, 8'h00, 0);
    vecs[4]  = mk(1, 0, 3'b101, 32'h8000_0010, 32'h0, 5'd5, 32'h0000_8001, 32'h0000_8001, 8'h00, 0);
    vecs[5]  = mk(1, 0, 3'b000, 32'h8000_0021, 32'h0, 5'd6, 32'hFFFF_FF7F, 32'h0000_007F, 8'h00, 0);
    vecs[6]  = mk(1, 0, 3'b100, 32'h8000_0022, 32'h0, 5'd8, 32'h1234_56F0, 32'h0000_00F0, 8'h00, 0);
    vecs[7]  = mk(0, 1, 3'b001, 32'h8000_0102, 32'h1234_ABCD, 5'd9, 32'hAAAA_AAAA, 32'h0, 8'h03, 0);
    vecs[8]  = mk(0, 1, 3'b000, 32'h8000_0201, 32'h0000_00EE, 5'd10, 32'h1111_1111, 32'h0, 8'h01, 0);
    vecs[9]  = mk(0, 1, 3'b010, 32'h8000_0300, 32'hCAFE_BABE, 5'd11, 32'h0, 32'h0, 8'h0F, 0);
    vecs[10] = mk(0, 1, 3'b111, 32'h8000_0304, 32'h0102_0304, 5'd12, 32'h0, 32'h0, 8'h0F, 0);
    vecs[11] = mk(0, 0, 3'b010, 32'h8000_0400, 32'h9999_9999, 5'd7, 32'h5555_5555, 32'h0, 8'h00, 0);
    vecs[12] = mk(1, 1, 3'b010, 32'h8000_0500, 32'h7777_7777, 5'd13, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'h00, 0);
    vecs[13] = mk(1, 0, 3'b011, 32'h8000_0600, 32'h0, 5'd14, 32'h8765_4321, 32'h8765_4321, 8'h00, 0);
    vecs[14] = mk(1, 0, 3'b110, 32'h8000_0604, 32'h0, 5'd15, 32'hF000_00FF, 32'hF000_00FF, 8'h00, 0);
    vecs[15] = mk(1, 0, 3'b010, 32'h8000_0700, 32'h0, 5'd16, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 8'h00, 5);

    repeat (2) @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, out_is_load, mem_ren, mem_wen}, 5'b10000);
    check("reset_data", {mem_raddr, out_rdata, mem_wmask, out_rd}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 8; i++) begin
      v = mk(1, 0, f3s[$urandom_range(0, 4)], $urandom, 32'h0, 5'($urandom_range(1, 31)),
             $urandom, 32'h0, 8'h00, $urandom_range(0, 2));
      v.exp_rdata = ref_load(v.f3, v.rdata);
      run_op($sformatf("rnd%0d", i), v);
    end

    // Asynchronous reset in the second ACCESS cycle of a load.
    @(negedge clk);
    drive_req(mk(1, 0, 3'b010, 32'h8000_0800, 32'h0, 5'd20, 32'h1357_9BDF, 32'h0, 8'h00, 0));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_access_ren", mem_ren, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {mem_ren, mem_wen, out_valid, in_ready}, 4'b0001);
    check("async_reset_regs", {mem_raddr, out_rd}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", mk(1, 0, 3'b010, 32'h8000_0900, 32'h0, 5'd21, 32'h2468_ACE0,
                             32'h2468_ACE0, 8'h00, 0));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
